// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: steps the CPU through IF/ID/EX/MEM/WB on
// phase-qualified cycles, issuing memory requests and single-cycle datapath strobes.
module cycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ph_en,
  input  logic             run,
  input  logic             step,
  input  logic             mem_ready,
  input  logic             needs_mem,
  input  logic             is_store,
  input  logic             wb_en,
  input  logic             halt_req,
  output logic [4:0]       stage,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IF   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       step_pend;
  logic       start;
  logic       in_instr;

  // Memory handshake: mem_req stays high until mem_ready is seen in a cycle
  // with ph_en=1; the access completes on that clock edge.
  assign start    = (state == S_IDLE) && ph_en && (run || step_pend);
  assign in_instr = (state == S_IF) || (state == S_ID) || (state == S_EX) ||
                    (state == S_MEM) || (state == S_WB);

  always_comb begin
    state_nxt = state;
    if (ph_en) begin
      case (state)
        S_IDLE:  if (run || step_pend) state_nxt = S_IF;
        S_IF:    if (mem_ready) state_nxt = S_ID;
        S_ID:    state_nxt = halt_req ? S_HALT : S_EX;
        S_EX:    state_nxt = needs_mem ? S_MEM : S_WB;
        S_MEM:   if (mem_ready) state_nxt = S_WB;
        S_WB:    state_nxt = run ? S_IF : S_IDLE;
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobes fire in the cycle whose edge takes the transition, so the datapath
  // captures on the same edge as the state change.
  assign ir_we  = (state == S_IF) && ph_en && mem_ready;
  assign pc_we  = (state == S_WB) && ph_en;
  assign reg_we = pc_we && wb_en;

  always_comb begin
    stage   = 5'b00000;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    case (state)
      S_IF:    begin stage = 5'b00001; mem_req = 1'b1; end
      S_ID:    stage = 5'b00010;
      S_EX:    stage = 5'b00100;
      S_MEM:   begin stage = 5'b01000; mem_req = 1'b1; mem_we = is_store; end
      S_WB:    stage = 5'b10000;
      S_HALT:  halted = 1'b1;
      default: stage = 5'b00000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      step_pend <= 1'b0;
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start)
        step_pend <= 1'b0;
      else if ((state == S_IDLE) && step)
        step_pend <= 1'b1;
      if (pc_we)
        instr_cnt <= instr_cnt + CNT_ONE;
      if (in_instr)
        cycle_cnt <= cycle_cnt + CNT_ONE;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: a 32-bit counter instance and a 4-bit
// counter instance share all stimulus; expected values are hand-derived.
module tb_cycle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ph_en = 1'b0, run = 1'b0, step = 1'b0, mem_ready = 1'b0;
  logic needs_mem = 1'b0, is_store = 1'b0, wb_en = 1'b0, halt_req = 1'b0;

  logic [4:0]  stage, stage_4;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we, halted;
  logic        mem_req_4, mem_we_4, ir_we_4, pc_we_4, reg_we_4, halted_4;
  logic [31:0] instr_cnt, cycle_cnt;
  logic [3:0]  instr_cnt_4, cycle_cnt_4;
  logic [2:0]  state_dbg, state_dbg_4;

  int n_cmp = 0;
  int n_err = 0;
  int n_ir = 0, n_pc = 0, n_reg = 0;
  int base_ir, base_pc, base_reg;
  logic [31:0] exp_stage [4];

  cycle_sequencer dut (
    .clk(clk), .rst(rst), .ph_en(ph_en), .run(run), .step(step),
    .mem_ready(mem_ready), .needs_mem(needs_mem), .is_store(is_store),
    .wb_en(wb_en), .halt_req(halt_req), .stage(stage), .mem_req(mem_req),
    .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .halted(halted), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt),
    .state_dbg(state_dbg)
  );

  cycle_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ph_en(ph_en), .run(run), .step(step),
    .mem_ready(mem_ready), .needs_mem(needs_mem), .is_store(is_store),
    .wb_en(wb_en), .halt_req(halt_req), .stage(stage_4), .mem_req(mem_req_4),
    .mem_we(mem_we_4), .ir_we(ir_we_4), .pc_we(pc_we_4), .reg_we(reg_we_4),
    .halted(halted_4), .instr_cnt(instr_cnt_4), .cycle_cnt(cycle_cnt_4),
    .state_dbg(state_dbg_4)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ir_we)  n_ir++;
    if (pc_we)  n_pc++;
    if (reg_we) n_reg++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_stage[0] = 32'd1;
    exp_stage[1] = 32'd2;
    exp_stage[2] = 32'd4;
    exp_stage[3] = 32'd16;

    // reset state
    tick();
    tick();
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_strobes", {29'd0, ir_we, pc_we, reg_we}, 32'd0);
    chk("rst_instr", instr_cnt, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_state4", 32'(state_dbg_4), 32'd0);
    rst = 1'b0;

    // free run: three non-memory instructions back to back
    run = 1'b1; ph_en = 1'b1; mem_ready = 1'b1; needs_mem = 1'b0; wb_en = 1'b1;
    base_ir = n_ir; base_pc = n_pc; base_reg = n_reg;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("fr_stage", 32'(stage), exp_stage[(k - 1) % 4]);
      chk("fr_ir_we", 32'(ir_we), 32'((k % 4) == 1));
      chk("fr_pc_we", 32'(pc_we), 32'((k % 4) == 0));
      chk("fr_reg_we", 32'(reg_we), 32'((k % 4) == 0));
      if (k == 12) run = 1'b0;
    end
    tick();
    chk("fr_idle", 32'(stage), 32'd0);
    chk("fr_instr", instr_cnt, 32'd3);
    chk("fr_cycle", cycle_cnt, 32'd12);
    chk("fr_n_ir", 32'(n_ir - base_ir), 32'd3);
    chk("fr_n_pc", 32'(n_pc - base_pc), 32'd3);
    chk("fr_n_reg", 32'(n_reg - base_reg), 32'd3);

    // memory store with three wait states, no register writeback
    run = 1'b1; needs_mem = 1'b1; is_store = 1'b1; wb_en = 1'b0;
    base_reg = n_reg;
    tick();
    run = 1'b0;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    settle();
    chk("mw_stage", 32'(stage), 32'd8);
    chk("mw_req_we", {30'd0, mem_req, mem_we}, 32'd3);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("mw_hold_stage", 32'(stage), 32'd8);
      chk("mw_hold_req_we", {30'd0, mem_req, mem_we}, 32'd3);
    end
    mem_ready = 1'b1;
    tick();
    chk("mw_wb_stage", 32'(stage), 32'd16);
    chk("mw_pc_we", 32'(pc_we), 32'd1);
    chk("mw_reg_we", 32'(reg_we), 32'd0);
    tick();
    chk("mw_idle", 32'(stage), 32'd0);
    chk("mw_instr", instr_cnt, 32'd4);
    chk("mw_cycle", cycle_cnt, 32'd20);
    chk("mw_n_reg", 32'(n_reg - base_reg), 32'd0);

    // single step requested while ph_en is low
    needs_mem = 1'b0; is_store = 1'b0; wb_en = 1'b1; ph_en = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    ph_en = 1'b1;
    settle();
    chk("ss_wait_idle", 32'(stage), 32'd0);
    tick();
    chk("ss_if", 32'(stage), 32'd1);
    ph_en = 1'b0;
    settle();
    chk("ss_ir_noadv", 32'(ir_we), 32'd0);
    tick();
    chk("ss_if_hold", 32'(stage), 32'd1);
    ph_en = 1'b1;
    settle();
    chk("ss_ir_we", 32'(ir_we), 32'd1);
    tick();
    tick();
    chk("ss_ex", 32'(stage), 32'd4);
    step = 1'b1;
    tick();
    step = 1'b0;
    settle();
    chk("ss_wb_strobes", {30'd0, pc_we, reg_we}, 32'd3);
    tick();
    tick();
    tick();
    chk("ss_stays_idle", 32'(stage), 32'd0);
    chk("ss_instr", instr_cnt, 32'd5);
    chk("ss_cycle", cycle_cnt, 32'd25);

    // halt at ID exit, with a stalled ID first
    run = 1'b1; halt_req = 1'b1;
    base_pc = n_pc;
    tick();
    tick();
    ph_en = 1'b0;
    tick();
    chk("ht_id_hold", 32'(stage), 32'd2);
    ph_en = 1'b1;
    tick();
    chk("ht_halted", 32'(halted), 32'd1);
    chk("ht_stage", 32'(stage), 32'd0);
    chk("ht_mem_req", 32'(mem_req), 32'd0);
    run = 1'b0; step = 1'b1;
    tick();
    step = 1'b0; run = 1'b1;
    tick();
    tick();
    chk("ht_stays", 32'(halted), 32'd1);
    chk("ht_instr", instr_cnt, 32'd5);
    chk("ht_cycle", cycle_cnt, 32'd28);
    chk("ht_n_pc", 32'(n_pc - base_pc), 32'd0);

    // reset clears halt, then reset again in the middle of a MEM wait
    halt_req = 1'b0;
    rst = 1'b1;
    settle();
    chk("rh_halted", 32'(halted), 32'd0);
    chk("rh_instr", instr_cnt, 32'd0);
    tick();
    rst = 1'b0; needs_mem = 1'b1; is_store = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("rm_mem_req_we", {30'd0, mem_req, mem_we}, 32'd2);
    chk("rm_cycle_pre", cycle_cnt, 32'd4);
    rst = 1'b1;
    settle();
    chk("rm_stage", 32'(stage), 32'd0);
    chk("rm_mem_req", 32'(mem_req), 32'd0);
    chk("rm_strobes", {29'd0, ir_we, pc_we, reg_we}, 32'd0);
    chk("rm_cycle", cycle_cnt, 32'd0);
    tick();
    rst = 1'b0; mem_ready = 1'b1; needs_mem = 1'b0;
    tick();
    chk("rm_enter_if", 32'(stage), 32'd1);

    // counter wrap on the 4-bit instance: 16 instructions, 64 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 61) chk("wr_instr15", 32'(instr_cnt_4), 32'd15);
      if (k == 64) begin
        chk("wr_cycle15", 32'(cycle_cnt_4), 32'd15);
        run = 1'b0;
      end
    end
    tick();
    chk("wr_instr_wrap", 32'(instr_cnt_4), 32'd0);
    chk("wr_cycle_wrap", 32'(cycle_cnt_4), 32'd0);
    chk("wr_instr32", instr_cnt, 32'd16);
    chk("wr_cycle32", cycle_cnt, 32'd64);
    chk("wr_idle4", {22'd0, stage_4, halted_4, mem_req_4, mem_we_4, state_dbg_4}, 32'd0);
    chk("wr_strobes4", {29'd0, ir_we_4, pc_we_4, reg_we_4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
